axilite_rd_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI4-Lite read channel's user-side command/response port among `NUM_REQ` requesters. It sits in front of the read channel's `user_rd_*` interface. Each accepted command has its requester ID pushed into an in-order tag FIFO, and each returned read word goes back to the requester that issued it. The arbiter caps the number of outstanding reads and flags responses that arrive with no matching command.

---
 rtl/axilite_rd_arbiter.sv | 167 ++++++++++++++++
 tb/tb_axilite_rd_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_rd_arbiter.sv
// Round-robin sharing of one AXI4-Lite read command/response port among NUM_REQ requesters.
// Grant and response each appear 1 cycle after the triggering edge; commands wait in ARB_ISSUE while user_rd_ready is low.

// In-order tag store; push and pop in the same cycle are both honoured.
// Read data is the current head, 0 cycles; the caller must not push when full or pop when empty.
module axilite_rd_arbiter_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign empty   = (count == '0);
endmodule

module axilite_rd_arbiter #(
    parameter int NUM_REQ            = 4,
    parameter int AXI_ADDR_WIDTH     = 32,
    parameter int USER_RD_DATA_WIDTH = 32,
    parameter int MAX_OUTSTANDING    = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_REQ-1:0]                  req_rd_en,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_rd_addr,
    output logic [NUM_REQ-1:0]                  req_rd_ready,
    output logic [USER_RD_DATA_WIDTH-1:0]       req_rd_data,
    output logic [NUM_REQ-1:0]                  req_rd_valid,
    output logic                                user_rd_en,
    output logic [AXI_ADDR_WIDTH-1:0]           user_rd_addr,
    input  logic                                user_rd_ready,
    input  logic [USER_RD_DATA_WIDTH-1:0]       user_rd_data,
    input  logic                                user_rd_valid,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_cnt,
    output logic                                rsp_orphan_err
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic {ARB_IDLE = 1'b0, ARB_ISSUE = 1'b1} arb_state_t;

    arb_state_t     state_q;
    arb_state_t     state_d;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] issue_id;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] win_next;
    logic           win_found;
    logic           grant;
    logic           accept;
    logic           rsp_pop;
    logic           rsp_orphan;
    logic [IDW-1:0] head_tag;
    logic           fifo_empty;

    // The count gates grants, so a push can never land on a full tag store.
    axilite_rd_arbiter_fifo #(
        .W     (IDW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (accept),
        .push_dat (issue_id),
        .pop      (rsp_pop),
        .pop_dat  (head_tag),
        .empty    (fifo_empty),
        .count    (outstanding_cnt)
    );

    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!win_found && req_rd_en[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
        win_next = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ARB_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (grant)  state_d = ARB_ISSUE;
            ARB_ISSUE: if (accept) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        grant      = (state_q == ARB_IDLE) && win_found && user_rd_ready &&
                     (outstanding_cnt < CW'(MAX_OUTSTANDING));
        accept     = (state_q == ARB_ISSUE) && user_rd_en && user_rd_ready;
        rsp_pop    = user_rd_valid && !fifo_empty;
        rsp_orphan = user_rd_valid && fifo_empty;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr         <= '0;
            issue_id       <= '0;
            req_rd_ready   <= '0;
            req_rd_valid   <= '0;
            req_rd_data    <= '0;
            user_rd_en     <= 1'b0;
            user_rd_addr   <= '0;
            rsp_orphan_err <= 1'b0;
        end else begin
            req_rd_ready <= grant ? (NUM_REQ'(1) << win_id) : '0;
            if (grant) begin
                user_rd_en   <= 1'b1;
                user_rd_addr <= req_rd_addr[int'(win_id)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                issue_id     <= win_id;
                rr_ptr       <= win_next;
            end else if (accept) begin
                user_rd_en   <= 1'b0;
            end

            req_rd_valid <= rsp_pop ? (NUM_REQ'(1) << head_tag) : '0;
            if (rsp_pop)    req_rd_data    <= user_rd_data;
            if (rsp_orphan) rsp_orphan_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axilite_rd_arbiter.sv
// Directed bench for axilite_rd_arbiter: inputs change 1ns after each rising edge, outputs checked there too.
module tb_axilite_rd_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 8;

    logic             clk;
    logic             reset_n;
    logic [NR-1:0]    req_rd_en;
    logic [NR*AW-1:0] req_rd_addr;
    logic [NR-1:0]    req_rd_ready;
    logic [DW-1:0]    req_rd_data;
    logic [NR-1:0]    req_rd_valid;
    logic             user_rd_en;
    logic [AW-1:0]    user_rd_addr;
    logic             user_rd_ready;
    logic [DW-1:0]    user_rd_data;
    logic             user_rd_valid;
    logic [3:0]       outstanding_cnt;
    logic             rsp_orphan_err;

    int n_chk  = 0;
    int n_fail = 0;

    axilite_rd_arbiter #(
        .NUM_REQ            (NR),
        .AXI_ADDR_WIDTH     (AW),
        .USER_RD_DATA_WIDTH (DW),
        .MAX_OUTSTANDING    (MO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_rd_en       (req_rd_en),
        .req_rd_addr     (req_rd_addr),
        .req_rd_ready    (req_rd_ready),
        .req_rd_data     (req_rd_data),
        .req_rd_valid    (req_rd_valid),
        .user_rd_en      (user_rd_en),
        .user_rd_addr    (user_rd_addr),
        .user_rd_ready   (user_rd_ready),
        .user_rd_data    (user_rd_data),
        .user_rd_valid   (user_rd_valid),
        .outstanding_cnt (outstanding_cnt),
        .rsp_orphan_err  (rsp_orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v = 1;
        return v << i;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(req_rd_ready), 64'h0);
        chk({tag, "_valid"}, 64'(req_rd_valid), 64'h0);
        chk({tag, "_data"},  64'(req_rd_data), 64'h0);
        chk({tag, "_en"},    64'(user_rd_en), 64'h0);
        chk({tag, "_addr"},  64'(user_rd_addr), 64'h0);
        chk({tag, "_cnt"},   64'(outstanding_cnt), 64'h0);
        chk({tag, "_err"},   64'(rsp_orphan_err), 64'h0);
    endtask

    initial begin
        logic [DW-1:0] rsp [5];
        int            rq;

        reset_n       = 1'b0;
        req_rd_en     = '0;
        req_rd_addr   = '0;
        user_rd_ready = 1'b0;
        user_rd_data  = '0;
        user_rd_valid = 1'b0;
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        reset_n = 1'b1;

        // single read from requester 2
        req_rd_en   = 4'b0100;
        req_rd_addr[2*AW +: AW] = 32'h0000_0040;
        user_rd_ready = 1'b1;
        tick();
        chk("single_grant", 64'(req_rd_ready), 64'h4);
        chk("single_en",    64'(user_rd_en), 64'h1);
        chk("single_addr",  64'(user_rd_addr), 64'h40);
        req_rd_en = '0;
        tick();
        chk("single_grant_off", 64'(req_rd_ready), 64'h0);
        chk("single_en_off",    64'(user_rd_en), 64'h0);
        chk("single_cnt1",      64'(outstanding_cnt), 64'h1);
        user_rd_valid = 1'b1;
        user_rd_data  = 32'hDEAD_BEEF;
        tick();
        chk("single_rvalid", 64'(req_rd_valid), 64'h4);
        chk("single_rdata",  64'(req_rd_data), 64'hDEAD_BEEF);
        chk("single_cnt0",   64'(outstanding_cnt), 64'h0);
        user_rd_valid = 1'b0;
        tick();
        chk("single_rvalid_off", 64'(req_rd_valid), 64'h0);

        // round robin from a fresh reset: all four requesters held high
        reset_n = 1'b0;
        for (int i = 0; i < NR; i++) req_rd_addr[i*AW +: AW] = 32'h100 * (i + 1);
        req_rd_en = 4'b1111;
        tick();
        reset_n = 1'b1;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk($sformatf("rr_grant%0d", g), 64'(req_rd_ready), 64'(onehot(g % 4)));
            chk($sformatf("rr_addr%0d", g), 64'(user_rd_addr), 64'(32'h100 * ((g % 4) + 1)));
            tick();
            chk($sformatf("rr_gap%0d", g), 64'(req_rd_ready), 64'h0);
        end
        req_rd_en = '0;
        chk("rr_cnt5", 64'(outstanding_cnt), 64'h5);
        rsp[0] = 32'hAAAA_0000; rsp[1] = 32'hBBBB_1111; rsp[2] = 32'hCCCC_2222;
        rsp[3] = 32'hDDDD_3333; rsp[4] = 32'hEEEE_4444;
        user_rd_valid = 1'b1;
        user_rd_data  = rsp[0];
        for (int r = 0; r < 5; r++) begin
            tick();
            chk($sformatf("rr_rsp_valid%0d", r), 64'(req_rd_valid), 64'(onehot(r % 4)));
            chk($sformatf("rr_rsp_data%0d", r), 64'(req_rd_data), 64'(rsp[r]));
            if (r < 4) user_rd_data = rsp[r + 1];
            else       user_rd_valid = 1'b0;
        end
        tick();
        chk("rr_rsp_idle", 64'(req_rd_valid), 64'h0);
        chk("rr_cnt0", 64'(outstanding_cnt), 64'h0);

        // backpressure: requester 1 (pointer is at 1 after five grants)
        req_rd_en = 4'b0010;
        req_rd_addr[1*AW +: AW] = 32'h0000_1234;
        tick();
        chk("bp_grant", 64'(req_rd_ready), 64'h2);
        chk("bp_en",    64'(user_rd_en), 64'h1);
        req_rd_en     = '0;
        user_rd_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp_hold_en%0d", c), 64'(user_rd_en), 64'h1);
            chk($sformatf("bp_hold_addr%0d", c), 64'(user_rd_addr), 64'h1234);
            chk($sformatf("bp_hold_cnt%0d", c), 64'(outstanding_cnt), 64'h0);
        end
        user_rd_ready = 1'b1;
        tick();
        chk("bp_accept_en", 64'(user_rd_en), 64'h0);
        chk("bp_accept_cnt", 64'(outstanding_cnt), 64'h1);
        tick();
        chk("bp_single_push", 64'(outstanding_cnt), 64'h1);
        user_rd_valid = 1'b1;
        user_rd_data  = 32'h0000_0055;
        tick();
        chk("bp_rsp_valid", 64'(req_rd_valid), 64'h2);
        chk("bp_rsp_cnt",   64'(outstanding_cnt), 64'h0);
        user_rd_valid = 1'b0;

        // outstanding cap: pointer at 2, grants go 2,3,0,1,2,3,0,1
        req_rd_en = 4'b1111;
        for (int g = 0; g < MO; g++) begin
            tick();
            chk($sformatf("cap_grant%0d", g), 64'(req_rd_ready), 64'(onehot((g + 2) % 4)));
            tick();
        end
        chk("cap_cnt8", 64'(outstanding_cnt), 64'h8);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("cap_nogrant%0d", c), 64'(req_rd_ready), 64'h0);
            chk($sformatf("cap_noen%0d", c), 64'(user_rd_en), 64'h0);
        end
        user_rd_valid = 1'b1;
        user_rd_data  = 32'h1111_2222;
        tick();
        chk("cap_rsp_valid", 64'(req_rd_valid), 64'h4);
        chk("cap_cnt7", 64'(outstanding_cnt), 64'h7);
        user_rd_valid = 1'b0;
        tick();
        chk("cap_regrant", 64'(req_rd_ready), 64'h4);
        chk("cap_regrant_en", 64'(user_rd_en), 64'h1);
        user_rd_valid = 1'b1;
        user_rd_data  = 32'h3333_4444;
        tick();
        chk("cap_simul_cnt", 64'(outstanding_cnt), 64'h7);
        chk("cap_simul_valid", 64'(req_rd_valid), 64'h8);
        chk("cap_simul_data", 64'(req_rd_data), 64'h3333_4444);
        req_rd_en = '0;
        for (int r = 0; r < 7; r++) begin
            user_rd_data = 32'h7000_0000 + r;
            tick();
            chk($sformatf("cap_drain%0d", r), 64'(req_rd_valid), 64'(onehot(r % 4)));
        end
        user_rd_valid = 1'b0;
        tick();
        chk("cap_drain_cnt0", 64'(outstanding_cnt), 64'h0);

        // orphan response
        chk("orphan_pre", 64'(rsp_orphan_err), 64'h0);
        user_rd_valid = 1'b1;
        user_rd_data  = 32'h0000_0BAD;
        tick();
        chk("orphan_err", 64'(rsp_orphan_err), 64'h1);
        chk("orphan_novalid", 64'(req_rd_valid), 64'h0);
        chk("orphan_cnt", 64'(outstanding_cnt), 64'h0);
        user_rd_valid = 1'b0;
        tick();
        chk("orphan_sticky", 64'(rsp_orphan_err), 64'h1);
        chk("orphan_novalid2", 64'(req_rd_valid), 64'h0);

        // reset mid-flight with three outstanding (pointer at 3)
        req_rd_en = 4'b1111;
        for (int g = 0; g < 3; g++) begin
            tick();
            rq = (g + 3) % 4;
            chk($sformatf("mid_grant%0d", g), 64'(req_rd_ready), 64'(onehot(rq)));
            tick();
        end
        req_rd_en = '0;
        chk("mid_cnt3", 64'(outstanding_cnt), 64'h3);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        tick();
        reset_n = 1'b1;
        user_rd_valid = 1'b1;
        user_rd_data  = 32'h0000_0077;
        tick();
        chk("mid_orphan_err", 64'(rsp_orphan_err), 64'h1);
        chk("mid_orphan_novalid", 64'(req_rd_valid), 64'h0);
        chk("mid_orphan_cnt", 64'(outstanding_cnt), 64'h0);
        user_rd_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
